// File: rtl/mbscore_pipe_ctrl.sv
// MBScore pipeline sequencing controller: per-stage valid/metadata, RAW/load-use stall, jump flush, writeback.
// Optional operand forwarding is enabled by defining MBSCORE_FORWARD_EN.
module mbscore_pipe_ctrl #(
    parameter int DATA_WIDTH = 32,
    parameter int STAGES     = 5,
    parameter int RA_W       = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_valid,
    input  logic [DATA_WIDTH-1:0] if_inst,
    output logic                  if_ready,
    input  logic [RA_W-1:0]       id_rs_addr,
    input  logic [RA_W-1:0]       id_rt_addr,
    input  logic                  id_rs_used,
    input  logic                  id_rt_used,
    input  logic [RA_W-1:0]       id_rd_addr,
    input  logic                  id_reg_we,
    input  logic                  id_is_load,
    input  logic                  jump,
    input  logic                  ext_stall,
    output logic                  pc_we,
    output logic                  IR_we,
    output logic [DATA_WIDTH-1:0] id_inst,
    output logic [STAGES-2:0]     stage_valid,
    output logic                  hazard_stall,
    output logic [2:0]            fwd_a_sel,
    output logic [2:0]            fwd_b_sel,
    output logic                  wb_we,
    output logic [RA_W-1:0]       wb_addr,
    output logic [31:0]           retire_count
);

    localparam int LAST = STAGES - 1;

    logic [LAST:1]         vld_r;
    logic [RA_W-1:0]       rd_r [2:LAST];
    logic [LAST:2]         we_r;
    logic                  ld2_r;
    logic [DATA_WIDTH-1:0] id_inst_r;
    logic [31:0]           retire_r;

    logic [LAST:2]         match_a_s;
    logic [LAST:2]         match_b_s;
    logic [2:0]            sel_a_s;
    logic [2:0]            sel_b_s;
    logic                  raw_s;
    logic                  jmp_s;
    logic                  hz_s;

    // Register 0 never creates a dependency: it is hard-wired and never written.
    function automatic logic match_f(input logic v, input logic we, input logic [RA_W-1:0] rd,
                                     input logic [RA_W-1:0] src, input logic used);
        return v & we & (rd != {RA_W{1'b0}}) & (rd == src) & used;
    endfunction

    // Compare ID sources against every downstream stage destination.
    always_comb begin
        match_a_s = '0;
        match_b_s = '0;
        for (int k = 2; k <= LAST; k++) begin
            match_a_s[k] = match_f(vld_r[k], we_r[k], rd_r[k], id_rs_addr, id_rs_used);
            match_b_s[k] = match_f(vld_r[k], we_r[k], rd_r[k], id_rt_addr, id_rt_used);
        end
    end

`ifdef MBSCORE_FORWARD_EN
    // Youngest matching stage wins; only a load still in stage 2 cannot be forwarded.
    always_comb begin
        sel_a_s = 3'd0;
        sel_b_s = 3'd0;
        for (int k = LAST; k >= 2; k--) begin
            if (match_a_s[k]) begin
                sel_a_s = 3'(k);
            end else begin
                sel_a_s = sel_a_s;
            end
            if (match_b_s[k]) begin
                sel_b_s = 3'(k);
            end else begin
                sel_b_s = sel_b_s;
            end
        end
        raw_s = vld_r[1] & ld2_r & ((sel_a_s == 3'd2) | (sel_b_s == 3'd2));
    end
`else
    logic unused_s;
    assign unused_s = ld2_r;

    // Without forwarding any in-flight producer, including WB, stalls the consumer.
    always_comb begin
        sel_a_s = 3'd0;
        sel_b_s = 3'd0;
        raw_s   = vld_r[1] & ((|match_a_s) | (|match_b_s));
    end
`endif

    assign jmp_s = vld_r[2] & jump & ~ext_stall;
    assign hz_s  = raw_s & ~jmp_s;

    // Fetch-side enables; priority is reset, freeze, jump, hazard, then normal advance.
    always_comb begin
        pc_we    = 1'b0;
        IR_we    = 1'b0;
        if_ready = 1'b0;
        if (rst) begin
            pc_we = 1'b0;
        end else if (ext_stall) begin
            pc_we = 1'b0;
        end else if (jmp_s) begin
            pc_we = 1'b1;
        end else if (hz_s) begin
            pc_we = 1'b0;
        end else begin
            if_ready = 1'b1;
            pc_we    = if_valid;
            IR_we    = if_valid;
        end
    end

    // Hazard, forwarding and writeback indications, all quiet during reset.
    always_comb begin
        hazard_stall = 1'b0;
        fwd_a_sel    = 3'd0;
        fwd_b_sel    = 3'd0;
        wb_we        = 1'b0;
        if (rst) begin
            hazard_stall = 1'b0;
        end else begin
            hazard_stall = hz_s;
            fwd_a_sel    = sel_a_s;
            fwd_b_sel    = sel_b_s;
            wb_we        = vld_r[LAST] & we_r[LAST] & (rd_r[LAST] != {RA_W{1'b0}}) & ~ext_stall;
        end
    end

    // Pipeline state: stages 2..last always advance unless frozen; ID holds on hazard.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_r     <= '0;
            we_r      <= '0;
            ld2_r     <= 1'b0;
            id_inst_r <= {DATA_WIDTH{1'b0}};
            retire_r  <= 32'd0;
            for (int k = 2; k <= LAST; k++) begin
                rd_r[k] <= {RA_W{1'b0}};
            end
        end else if (ext_stall) begin
            vld_r    <= vld_r;
            we_r     <= we_r;
            ld2_r    <= ld2_r;
            retire_r <= retire_r;
        end else begin
            for (int k = 3; k <= LAST; k++) begin
                vld_r[k] <= vld_r[k-1];
                we_r[k]  <= we_r[k-1];
                rd_r[k]  <= rd_r[k-1];
            end
            rd_r[2] <= id_rd_addr;
            if (jmp_s) begin
                vld_r[1] <= 1'b0;
                vld_r[2] <= 1'b0;
                we_r[2]  <= 1'b0;
                ld2_r    <= 1'b0;
            end else if (hz_s) begin
                vld_r[1] <= vld_r[1];
                vld_r[2] <= 1'b0;
                we_r[2]  <= 1'b0;
                ld2_r    <= 1'b0;
            end else begin
                vld_r[1] <= if_valid;
                vld_r[2] <= vld_r[1];
                we_r[2]  <= id_reg_we;
                ld2_r    <= id_is_load;
            end
            if (IR_we) begin
                id_inst_r <= if_inst;
            end else begin
                id_inst_r <= id_inst_r;
            end
            if (vld_r[LAST]) begin
                retire_r <= retire_r + 32'd1;
            end else begin
                retire_r <= retire_r;
            end
        end
    end

    assign stage_valid  = vld_r;
    assign id_inst      = id_inst_r;
    assign wb_addr      = rd_r[LAST];
    assign retire_count = retire_r;

endmodule
